// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the execute-stage ALU with its iterative
// multiply/divide unit.
//   alu_op_e      : 4-bit operation encodings (op[3]=0 single-cycle ALU ops,
//                   op[3]=1 HI/LO and multiply/divide ops)
//   md_state_e    : multiply/divide sequencer states
//   DIVZ_LO_FILL  : bit replicated across LO on a divide by zero
//   DIVOVF_HI_VAL : HI value for the signed-overflow divide (most-negative / -1)
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SLTU  = 4'b0011,
    OP_ANDN  = 4'b0100,
    OP_ORN   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULT  = 4'b1000,
    OP_MULTU = 4'b1001,
    OP_DIV   = 4'b1010,
    OP_DIVU  = 4'b1011,
    OP_MFHI  = 4'b1100,
    OP_MFLO  = 4'b1101,
    OP_MTHI  = 4'b1110,
    OP_MTLO  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } md_state_e;

  // Divide by zero: LO becomes all ones, HI receives the dividend unchanged.
  localparam logic DIVZ_LO_FILL = 1'b1;
  // Signed overflow leaves a zero remainder; the quotient equals the dividend
  // and falls out of the normal magnitude/negate path.
  localparam logic DIVOVF_HI_VAL = 1'b0;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Iterative multiply/divide sequencer with the architectural HI/LO registers.
// One radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
// per cycle on operand magnitudes; signs are applied in the FIN state.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   op, start    : operation and request; MULT/DIV start the FSM,
//                  MTHI/MTLO write HI/LO directly when idle
//   a, b         : operands (a = dividend / MTHI-MTLO source)
//   busy         : multiply/divide in progress
//   done         : one-cycle pulse when HI/LO were written by MULT/DIV
//   hi, lo       : HI/LO registers
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // Iteration datapath: acc_q is the running high half (multiply) or
  // partial remainder (divide); mq_q holds multiplier/dividend bits and
  // collects product low bits or quotient bits.
  logic [WIDTH-1:0] acc_q, mq_q, mag_q, dvd_q;
  logic             div_q, sgn_q, rneg_q, dz_q;

  logic             accept, is_signed, a_neg, b_neg;
  logic             mt_hi, mt_lo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shl, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign accept    = (state_q == IDLE) && start && op[3] && !op[2];
  assign mt_hi     = (state_q == IDLE) && start && (op == OP_MTHI);
  assign mt_lo     = (state_q == IDLE) && start && (op == OP_MTLO);
  assign is_signed = !op[0];
  assign a_neg     = is_signed && a[WIDTH-1];
  assign b_neg     = is_signed && b[WIDTH-1];

  always_comb begin
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mag_q} : '0);
    div_shl  = {acc_q, mq_q[WIDTH-1]};
    div_diff = div_shl - {1'b0, mag_q};
    prod     = {acc_q, mq_q};
    prod_fix = sgn_q ? -prod : prod;
    quo_fix  = sgn_q ? -mq_q : mq_q;
    rem_fix  = rneg_q ? -acc_q : acc_q;
  end

  // Control FSM, iteration counter and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            state_q <= RUN;
          end else if (mt_hi) begin
            hi_q <= a;
          end else if (mt_lo) begin
            lo_q <= a;
          end
        end
        RUN: begin
          if (cnt_q == LAST) begin
            state_q <= FIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (!div_q) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (dz_q) begin
            lo_q <= {WIDTH{DIVZ_LO_FILL}};
            hi_q <= dvd_q;
          end else begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Iteration datapath: operands frozen at acceptance, one step per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q  <= '0;
      mq_q   <= a_mag;
      mag_q  <= b_mag;
      dvd_q  <= a;
      div_q  <= op[1];
      sgn_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dz_q   <= (b == '0);
    end else if (state_q == RUN) begin
      if (div_q) begin
        // Restoring step: keep the difference only if it did not borrow.
        if (!div_diff[WIDTH]) begin
          acc_q <= div_diff[WIDTH-1:0];
          mq_q  <= {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_q <= div_shl[WIDTH-1:0];
          mq_q  <= {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Shift-add: the carry out of the add becomes the new top bit.
        acc_q <= mul_sum[WIDTH:1];
        mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv
// Execute-stage ALU: single-cycle logic/arithmetic ops, signed/unsigned
// set-less-than, HI/LO moves and an iterative multiply/divide unit.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   op         : 4-bit operation (alu_pkg::alu_op_e)
//   start      : request for MULT/DIV/MTHI/MTLO
//   a, b       : operands (a = rs, b = rt)
//   y, zero    : combinational result and its all-zero flag
//   busy, done : multiply/divide in progress / HI-LO written pulse
//   hi, lo     : architectural HI/LO registers
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_op_e                 op_e;
  logic signed [WIDTH-1:0] a_s, b_s;

  assign op_e = alu_op_e'(op);
  assign a_s  = a;
  assign b_s  = b;

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always_comb begin
    y = '0;
    case (op_e)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      // HI/LO reads are live even while a multiply/divide is running.
      OP_MFHI: y = hi;
      OP_MFLO: y = lo;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op, op8;
  logic        start, start8;
  logic [31:0] a, b, y, hi, lo;
  logic [7:0]  a8, b8, y8, hi8, lo8;
  logic        zero, busy, done, zero8, busy8, done8;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int acc_cyc, acc8_cyc;
  int ndone = 0, ndone8 = 0;
  logic [63:0] sb[$];
  logic [15:0] sb8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op(op), .start(start), .a(a), .b(b),
    .y(y), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .op(op8), .start(start8), .a(a8), .b(b8),
    .y(y8), .zero(zero8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
    int signed sx, sz;
    sx = x; sz = z;
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x + z;
      3'd3: return (x < z) ? 32'd1 : 32'd0;
      3'd4: return x & ~z;
      3'd5: return x | ~z;
      3'd6: return x - z;
      default: return (sx < sz) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Returns {hi, lo}
  function automatic logic [63:0] model32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
    longint sx, sz, q, r;
    longint unsigned ux, uz, uq, ur;
    logic [63:0] res;
    sx = longint'($signed(x)); sz = longint'($signed(z));
    ux = {32'd0, x}; uz = {32'd0, z};
    res = '0;
    case (o)
      OP_MULT:  res = sx * sz;
      OP_MULTU: res = ux * uz;
      OP_DIV: begin
        if (z == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) res = {32'd0, x};
        else begin
          q = sx / sz; r = sx % sz;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (z == 32'd0) res = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uz; ur = ux % uz;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Call at a negedge: drives a start pulse and records the expected HI/LO.
  task automatic issue32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
    op = o; a = x; b = z; start = 1'b1;
    acc_cyc = cyc;
    sb.push_back(model32(o, x, z));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done32(input string tag);
    int k;
    k = 0;
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      check_eq({tag, "_latency"}, 64'(cyc - acc_cyc - 1), 64'd33);
      check_eq({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
    end
  endtask

  // Scoreboards: each done pops one expected HI/LO pair.
  always @(negedge clk) begin
    if (done) begin
      ndone++;
      if (sb.size() == 0) check_eq("spurious_done", 64'd1, 64'd0);
      else check_eq("hilo", {hi, lo}, sb.pop_front());
    end
    if (done8) begin
      ndone8++;
      if (sb8.size() == 0) check_eq("spurious_done8", 64'd1, 64'd0);
      else check_eq("hilo8", {48'd0, hi8, lo8}, {48'd0, sb8.pop_front()});
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, k;
    logic [31:0] ra, rb, old_lo;
    logic [3:0] mo;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    check_eq("rst_busy_done", {62'd0, busy, done}, 64'd0);
    check_eq("rst8", {46'd0, hi8, lo8, busy8, done8}, 64'd0);

    // Combinational ops
    op = OP_ADD; a = 32'hFFFF_FFFF; b = 32'd1; #1;
    check_eq("add_wrap", {31'd0, zero, y}, {31'd1, 32'd0});
    op = OP_SLT; #1;
    check_eq("slt", {31'd0, zero, y}, {31'd0, 32'd1});
    op = OP_SLTU; #1;
    check_eq("sltu", {31'd0, zero, y}, {31'd1, 32'd0});
    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = (i % 3 == 0) ? ra : $urandom;
      op = {1'b0, 3'(i % 8)}; a = ra; b = rb; #1;
      check_eq("comb", {32'd0, y}, {32'd0, alu_ref(3'(i % 8), ra, rb)});
      check_eq("comb_zero", {63'd0, zero}, {63'd0, alu_ref(3'(i % 8), ra, rb) == 32'd0});
    end
    op = OP_MULT; #1;
    check_eq("y_muldiv_zero", {32'd0, y}, 64'd0);

    // Directed multiply/divide, each issued in the previous done cycle
    @(negedge clk);
    issue32(OP_MULT, 32'hFFFF_FFFE, 32'd3);  wait_done32("mult");
    issue32(OP_MULTU, 32'hFFFF_FFFE, 32'd3); wait_done32("multu");
    issue32(OP_DIV, 32'hFFFF_FFF9, 32'd2);   wait_done32("div");
    issue32(OP_DIVU, 32'd7, 32'd0);          wait_done32("divz");
    issue32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done32("divovf");
    issue32(OP_DIV, 32'd7, 32'd0);           wait_done32("divz_s");
    for (int i = 0; i < 8; i++) begin
      mo = {2'b10, 2'(i % 4)};
      ra = $urandom; rb = (i == 5) ? 32'd0 : ((i % 2) ? $urandom : ($urandom & 32'h0000_0FFF) | 32'h1);
      issue32(mo, ra, rb); wait_done32("rand");
    end

    // Changes and a second start while busy are ignored
    @(negedge clk);
    d0 = ndone;
    issue32(OP_MULT, 32'd5, 32'hFFFF_FFF7);
    repeat (4) @(negedge clk);
    op = OP_DIVU; a = 32'd99; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'h1111; b = 32'h2222;
    wait_done32("ignore");
    repeat (40) @(negedge clk);
    check_eq("one_done", 64'(ndone - d0), 64'd1);

    // MTHI/MTLO and HI/LO reads
    op = OP_MTLO; a = 32'h55; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("mtlo", {32'd0, lo}, 64'h55);
    op = OP_MTHI; a = 32'h1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("no_done_mt", {63'd0, done}, 64'd0);
    op = OP_MFHI; #1;
    check_eq("mfhi", {32'd0, y}, 64'h1234);
    old_lo = lo;
    @(negedge clk);
    issue32(OP_MULTU, 32'd3, 32'd4);
    op = OP_MFLO; #1;
    check_eq("mflo_busy", {32'd0, y}, {32'd0, old_lo});
    op = OP_MTLO; a = 32'hDEAD; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_eq("mtlo_busy", {32'd0, lo}, {32'd0, old_lo});
    wait_done32("mul_after_mt");

    // Reset in the middle of a divide
    @(negedge clk);
    issue32(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_state", {hi, lo}, 64'd0);
    check_eq("abort_busy_done", {62'd0, busy, done}, 64'd0);
    sb.delete();
    d0 = ndone;
    repeat (50) @(negedge clk);
    check_eq("abort_no_done", 64'(ndone - d0), 64'd0);

    // 8-bit instance
    op8 = OP_MULTU; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    acc8_cyc = cyc;
    sb8.push_back(16'hFE01);
    @(negedge clk); start8 = 1'b0;
    k = 0;
    while (!done8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!done8) check_eq("w8_timeout", 64'd0, 64'd1);
    else check_eq("w8_latency", 64'(cyc - acc8_cyc - 1), 64'd9);
    repeat (3) @(negedge clk);
    check_eq("w8_ndone", 64'(ndone8), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
